// File: rtl/video_pkg.sv
// Shared video types for the motion view compositor.
//   tile_sel_e         : quadrant selector for the 2x2 tiled output
//   rgb_t              : packed R/G/B pixel at the default channel width
//   DEFAULT_BORDER_RGB : full red, no green/blue
package video_pkg;

  localparam int unsigned RGB_DEFAULT_W = 4;

  typedef enum logic [1:0] {
    TILE_LT = 2'd0,
    TILE_RT = 2'd1,
    TILE_LB = 2'd2,
    TILE_RB = 2'd3
  } tile_sel_e;

  typedef struct packed {
    logic [RGB_DEFAULT_W-1:0] r;
    logic [RGB_DEFAULT_W-1:0] g;
    logic [RGB_DEFAULT_W-1:0] b;
  } rgb_t;

  localparam rgb_t DEFAULT_BORDER_RGB = '{r: '1, g: '0, b: '0};

endpackage

// File: rtl/motion_view_compositor_if.sv
// Pixel/control bundle between the video source and the compositor.
//   Source -> compositor : vref, x_local, y_local, display_enable, tile_sel,
//                          motion_detected, blink_en, tile0_rgb, tile1..3_y
//   Compositor -> source : frame_count, frame_done, alarm, red/green/blue_port
interface motion_view_compositor_if #(
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned FRAME_MOD = 3
) ();

  localparam int unsigned CNT_W = (FRAME_MOD > 1) ? $clog2(FRAME_MOD) : 1;

  logic                       vref;
  logic [9:0]                 x_local;
  logic [9:0]                 y_local;
  logic                       display_enable;
  video_pkg::tile_sel_e       tile_sel;
  logic                       motion_detected;
  logic                       blink_en;
  logic [3*COLOR_W-1:0]       tile0_rgb;
  logic [COLOR_W-1:0]         tile1_y;
  logic [COLOR_W-1:0]         tile2_y;
  logic [COLOR_W-1:0]         tile3_y;

  logic [CNT_W-1:0]           frame_count;
  logic                       frame_done;
  logic                       alarm;
  logic [COLOR_W-1:0]         red_port;
  logic [COLOR_W-1:0]         green_port;
  logic [COLOR_W-1:0]         blue_port;

  modport master (
    output vref, x_local, y_local, display_enable, tile_sel,
           motion_detected, blink_en, tile0_rgb, tile1_y, tile2_y, tile3_y,
    input  frame_count, frame_done, alarm, red_port, green_port, blue_port
  );

  modport slave (
    input  vref, x_local, y_local, display_enable, tile_sel,
           motion_detected, blink_en, tile0_rgb, tile1_y, tile2_y, tile3_y,
    output frame_count, frame_done, alarm, red_port, green_port, blue_port
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Frame tick generator: detects vref edges and keeps a modulo frame counter.
//   clk, reset   : clock, async active-high reset
//   vref         : camera frame sync
//   frame_done_c : one-cycle tick per qualifying vref edge (combinational)
//   frame_count  : registered frame index, wraps at FRAME_MOD
module frame_tick_gen #(
  parameter int unsigned FRAME_MOD = 3,
  parameter int unsigned EDGE_MODE = 0,
  parameter int unsigned CNT_W     = (FRAME_MOD > 1) ? $clog2(FRAME_MOD) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vref,
  output logic             frame_done_c,
  output logic [CNT_W-1:0] frame_count
);

  logic             prev_vref_q;
  logic [CNT_W-1:0] frame_count_q;
  logic [CNT_W-1:0] frame_count_d;

  // Any toggle, or rising edge only, relative to last cycle's vref.
  always_comb begin
    if (EDGE_MODE == 0) begin
      frame_done_c = vref ^ prev_vref_q;
    end else begin
      frame_done_c = vref & ~prev_vref_q;
    end
  end

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_done_c) begin
      if (frame_count_q == CNT_W'(FRAME_MOD - 1)) begin
        frame_count_d = '0;
      end else begin
        frame_count_d = frame_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vref_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      prev_vref_q   <= vref;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;

endmodule

// File: rtl/motion_view_compositor.sv
// Composites a 2x2 camera view: tile 0 in colour with a blinking alarm
// border on motion, tiles 1-3 greyscale. Also reports frame ticks/count.
//   clk, reset : clock, async active-high reset
//   bus        : motion_view_compositor_if slave (pixel inputs, control,
//                frame_count/frame_done/alarm and registered RGB outputs)
module motion_view_compositor
  import video_pkg::*;
#(
  parameter int unsigned COLOR_W        = 4,
  parameter int unsigned FRAME_MOD      = 3,
  parameter int unsigned EDGE_MODE      = 0,
  parameter int unsigned TILE_W         = 320,
  parameter int unsigned TILE_H         = 240,
  parameter int unsigned LINE_THICKNESS = 20,
  parameter int unsigned HOLD_FRAMES    = 30,
  parameter int unsigned BLINK_FRAMES   = 8,
  parameter logic [3*COLOR_W-1:0] BORDER_RGB =
    {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}}
) (
  input  logic                      clk,
  input  logic                      reset,
  motion_view_compositor_if.slave   bus
);

  localparam int unsigned CNT_W   = (FRAME_MOD > 1) ? $clog2(FRAME_MOD) : 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] X_LO = 10'(LINE_THICKNESS);
  localparam logic [9:0] X_HI = 10'(TILE_W - LINE_THICKNESS);
  localparam logic [9:0] Y_LO = 10'(LINE_THICKNESS);
  localparam logic [9:0] Y_HI = 10'(TILE_H - LINE_THICKNESS);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  function automatic pix_t grey(input logic [COLOR_W-1:0] v);
    return '{r: v, g: v, b: v};
  endfunction

  logic               frame_done_c;
  logic [HOLD_W-1:0]  hold_cnt_q,    hold_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               alarm_q,       alarm_d;
  pix_t               rgb_q,         rgb_d;
  logic               border_pix_c;
  logic               border_vis_c;

  frame_tick_gen #(
    .FRAME_MOD (FRAME_MOD),
    .EDGE_MODE (EDGE_MODE),
    .CNT_W     (CNT_W)
  ) u_frame_tick_gen (
    .clk          (clk),
    .reset        (reset),
    .vref         (bus.vref),
    .frame_done_c (frame_done_c),
    .frame_count  (bus.frame_count)
  );

  // Alarm hold and blink timing, all stepped once per frame.
  // Motion reloads the hold even when it is about to expire.
  always_comb begin
    hold_cnt_d    = hold_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_done_c) begin
      if (bus.motion_detected) begin
        hold_cnt_d = HOLD_W'(HOLD_FRAMES);
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
    alarm_d = (hold_cnt_q != '0);
  end

  // Border ring on the colour tile only.
  always_comb begin
    border_pix_c = (bus.tile_sel == TILE_LT) &&
                   ((bus.x_local < X_LO) || (bus.x_local >= X_HI) ||
                    (bus.y_local < Y_LO) || (bus.y_local >= Y_HI));
    border_vis_c = alarm_q && (!bus.blink_en || blink_phase_q);
  end

  // Pixel mux; blanking forces black.
  always_comb begin
    rgb_d = '0;
    if (bus.display_enable) begin
      case (bus.tile_sel)
        TILE_LT: rgb_d = (border_pix_c && border_vis_c) ? pix_t'(BORDER_RGB)
                                                        : pix_t'(bus.tile0_rgb);
        TILE_RT: rgb_d = grey(bus.tile1_y);
        TILE_LB: rgb_d = grey(bus.tile2_y);
        TILE_RB: rgb_d = grey(bus.tile3_y);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      alarm_q       <= 1'b0;
      rgb_q         <= '0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      alarm_q       <= alarm_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.frame_done = frame_done_c;
  assign bus.alarm      = alarm_q;
  assign bus.red_port   = rgb_q.r;
  assign bus.green_port = rgb_q.g;
  assign bus.blue_port  = rgb_q.b;

endmodule

// File: tb/tb_motion_view_compositor.sv
// Directed bench: dut0 uses toggle ticks (EDGE_MODE=0), dut1 rising-edge
// ticks (EDGE_MODE=1); both FRAME_MOD=3, HOLD_FRAMES=3, BLINK_FRAMES=2.
module tb_motion_view_compositor;
  import video_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   n0, n1;

  always #5 clk = ~clk;

  motion_view_compositor_if #(.COLOR_W(4), .FRAME_MOD(3)) bus0 ();
  motion_view_compositor_if #(.COLOR_W(4), .FRAME_MOD(3)) bus1 ();

  assign bus1.vref            = bus0.vref;
  assign bus1.x_local         = bus0.x_local;
  assign bus1.y_local         = bus0.y_local;
  assign bus1.display_enable  = bus0.display_enable;
  assign bus1.tile_sel        = bus0.tile_sel;
  assign bus1.motion_detected = bus0.motion_detected;
  assign bus1.blink_en        = bus0.blink_en;
  assign bus1.tile0_rgb       = bus0.tile0_rgb;
  assign bus1.tile1_y         = bus0.tile1_y;
  assign bus1.tile2_y         = bus0.tile2_y;
  assign bus1.tile3_y         = bus0.tile3_y;

  motion_view_compositor #(
    .COLOR_W(4), .FRAME_MOD(3), .EDGE_MODE(0), .HOLD_FRAMES(3), .BLINK_FRAMES(2)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  motion_view_compositor #(
    .COLOR_W(4), .FRAME_MOD(3), .EDGE_MODE(1), .HOLD_FRAMES(3), .BLINK_FRAMES(2)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic logic [11:0] out0();
    return {bus0.red_port, bus0.green_port, bus0.blue_port};
  endfunction

  task automatic init_inputs();
    bus0.vref            = 1'b0;
    bus0.x_local         = '0;
    bus0.y_local         = '0;
    bus0.display_enable  = 1'b0;
    bus0.tile_sel        = TILE_LT;
    bus0.motion_detected = 1'b0;
    bus0.blink_en        = 1'b0;
    bus0.tile0_rgb       = '0;
    bus0.tile1_y         = '0;
    bus0.tile2_y         = '0;
    bus0.tile3_y         = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    init_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One frame: tick with the given motion flag, then one settling cycle.
  task automatic frame_tick(input logic motion);
    bus0.motion_detected = motion;
    bus0.vref = ~bus0.vref;
    @(posedge clk);
    #1 bus0.motion_detected = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    init_inputs();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus0.alarm !== 1'b0 || bus0.frame_count !== 2'd0 || out0() !== 12'h000 ||
        bus0.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: alarm=%b count=%0d rgb=%h done=%b, want 0/0/000/0",
               bus0.alarm, bus0.frame_count, out0(), bus0.frame_done);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus0.alarm !== 1'b0 || bus0.frame_count !== 2'd0 || bus1.frame_count !== 2'd0) begin
      failures++;
      $display("FAIL reset_release: alarm=%b count0=%0d count1=%0d, want 0/0/0",
               bus0.alarm, bus0.frame_count, bus1.frame_count);
    end
  endtask

  task automatic test_frame_count();
    int exp_cnt [7] = '{1, 2, 0, 1, 2, 0, 1};
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 7; i++) begin
      bus0.vref = ~bus0.vref;
      #1;
      checks++;
      if (bus0.frame_done !== 1'b1) begin
        failures++;
        $display("FAIL toggle_tick[%0d]: frame_done=%b, want 1", i, bus0.frame_done);
      end
      if (bus0.frame_done === 1'b1) n0++;
      if (bus1.frame_done === 1'b1) n1++;
      @(posedge clk);
      #1;
      checks++;
      if (bus0.frame_done !== 1'b0) begin
        failures++;
        $display("FAIL tick_single_cycle[%0d]: frame_done=%b, want 0", i, bus0.frame_done);
      end
      checks++;
      if (int'(bus0.frame_count) != exp_cnt[i]) begin
        failures++;
        $display("FAIL frame_count[%0d]: got %0d, want %0d", i, bus0.frame_count, exp_cnt[i]);
      end
    end
    checks++;
    if (n0 != 7 || n1 != 4) begin
      failures++;
      $display("FAIL tick_totals: toggle=%0d rise=%0d, want 7/4", n0, n1);
    end
  endtask

  task automatic test_rising_edge();
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int p = 0; p < 4; p++) begin
      bus0.vref = 1'b1;
      #1;
      checks++;
      if (bus1.frame_done !== 1'b1) begin
        failures++;
        $display("FAIL rise_tick[%0d]: frame_done=%b, want 1", p, bus1.frame_done);
      end
      if (bus0.frame_done === 1'b1) n0++;
      if (bus1.frame_done === 1'b1) n1++;
      @(posedge clk);
      #1 bus0.vref = 1'b0;
      #1;
      checks++;
      if (bus1.frame_done !== 1'b0) begin
        failures++;
        $display("FAIL fall_no_tick[%0d]: frame_done=%b, want 0", p, bus1.frame_done);
      end
      if (bus0.frame_done === 1'b1) n0++;
      if (bus1.frame_done === 1'b1) n1++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n1 != 4 || n0 != 8 || bus1.frame_count !== 2'd1 || bus0.frame_count !== 2'd2) begin
      failures++;
      $display("FAIL rise_totals: rise=%0d toggle=%0d cnt1=%0d cnt0=%0d, want 4/8/1/2",
               n1, n0, bus1.frame_count, bus0.frame_count);
    end
  endtask

  task automatic test_hold();
    logic exp_a [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    bus0.motion_detected = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus0.motion_detected = 1'b0;
    checks++;
    if (bus0.alarm !== 1'b0) begin
      failures++;
      $display("FAIL motion_no_tick: alarm=%b, want 0", bus0.alarm);
    end
    bus0.motion_detected = 1'b1;
    bus0.vref = ~bus0.vref;
    @(posedge clk);
    #1 bus0.motion_detected = 1'b0;
    checks++;
    if (bus0.alarm !== 1'b0) begin
      failures++;
      $display("FAIL alarm_latency: alarm=%b, want 0", bus0.alarm);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus0.alarm !== 1'b1) begin
      failures++;
      $display("FAIL alarm_set: alarm=%b, want 1", bus0.alarm);
    end
    for (int i = 0; i < 3; i++) begin
      frame_tick(1'b0);
      checks++;
      if (bus0.alarm !== exp_a[i]) begin
        failures++;
        $display("FAIL hold_decay[%0d]: alarm=%b, want %b", i, bus0.alarm, exp_a[i]);
      end
    end
    frame_tick(1'b1);
    frame_tick(1'b0);
    frame_tick(1'b0);
    frame_tick(1'b1);
    checks++;
    if (bus0.alarm !== 1'b1) begin
      failures++;
      $display("FAIL hold_reload: alarm=%b, want 1", bus0.alarm);
    end
    for (int i = 0; i < 3; i++) begin
      frame_tick(1'b0);
      checks++;
      if (bus0.alarm !== exp_a[i]) begin
        failures++;
        $display("FAIL reload_decay[%0d]: alarm=%b, want %b", i, bus0.alarm, exp_a[i]);
      end
    end
    frame_tick(1'b0);
    checks++;
    if (bus0.alarm !== 1'b0) begin
      failures++;
      $display("FAIL hold_stays_zero: alarm=%b, want 0", bus0.alarm);
    end
  endtask

  task automatic test_border();
    logic [9:0]  xs   [10] = '{10'd0, 10'd19, 10'd20, 10'd319, 10'd299,
                               10'd300, 10'd100, 10'd100, 10'd100, 10'd100};
    logic [9:0]  ys   [10] = '{10'd100, 10'd100, 10'd100, 10'd100, 10'd100,
                               10'd100, 10'd19, 10'd20, 10'd219, 10'd220};
    logic [11:0] exps [10] = '{12'hF00, 12'hF00, 12'h5A3, 12'hF00, 12'h5A3,
                               12'hF00, 12'hF00, 12'h5A3, 12'h5A3, 12'hF00};
    logic [11:0] prev;
    do_reset();
    bus0.display_enable = 1'b1;
    bus0.tile0_rgb      = 12'h5A3;
    bus0.x_local        = 10'd150;
    bus0.y_local        = 10'd100;
    frame_tick(1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (bus0.alarm !== 1'b1 || bus0.red_port !== 4'h5 || bus0.green_port !== 4'hA ||
        bus0.blue_port !== 4'h3) begin
      failures++;
      $display("FAIL interior_colour: alarm=%b rgb=%h, want 1/5a3", bus0.alarm, out0());
    end
    prev = 12'h5A3;
    for (int i = 0; i < 10; i++) begin
      bus0.x_local = xs[i];
      bus0.y_local = ys[i];
      #1;
      checks++;
      if (out0() !== prev) begin
        failures++;
        $display("FAIL border_latency[%0d]: rgb=%h, want %h", i, out0(), prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out0() !== exps[i]) begin
        failures++;
        $display("FAIL border_pix[%0d] x=%0d y=%0d: rgb=%h, want %h",
                 i, xs[i], ys[i], out0(), exps[i]);
      end
      prev = exps[i];
    end
  endtask

  task automatic test_blink();
    logic [11:0] exps [6] = '{12'h5A3, 12'hF00, 12'hF00, 12'h5A3, 12'h5A3, 12'hF00};
    do_reset();
    bus0.display_enable = 1'b1;
    bus0.blink_en       = 1'b1;
    bus0.tile0_rgb      = 12'h5A3;
    bus0.x_local        = 10'd0;
    bus0.y_local        = 10'd100;
    for (int i = 0; i < 6; i++) begin
      frame_tick(1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (out0() !== exps[i]) begin
        failures++;
        $display("FAIL blink_frame[%0d]: rgb=%h, want %h", i + 1, out0(), exps[i]);
      end
    end
  endtask

  task automatic test_grey_and_reset();
    tile_sel_e   sels [4] = '{TILE_LB, TILE_RT, TILE_RB, TILE_LT};
    logic [11:0] exps [4] = '{12'h999, 12'h333, 12'hCCC, 12'h5A3};
    do_reset();
    bus0.display_enable = 1'b1;
    bus0.tile0_rgb      = 12'h5A3;
    bus0.tile1_y        = 4'h3;
    bus0.tile2_y        = 4'h9;
    bus0.tile3_y        = 4'hC;
    for (int i = 0; i < 4; i++) begin
      bus0.tile_sel = sels[i];
      @(posedge clk);
      #1;
      checks++;
      if (out0() !== exps[i]) begin
        failures++;
        $display("FAIL tile_mux[%0d]: rgb=%h, want %h", i, out0(), exps[i]);
      end
    end
    bus0.display_enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out0() !== 12'h000) begin
      failures++;
      $display("FAIL blanking: rgb=%h, want 000", out0());
    end
    bus0.display_enable = 1'b1;
    frame_tick(1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (bus0.alarm !== 1'b1 || out0() !== 12'hF00) begin
      failures++;
      $display("FAIL pre_reset_alarm: alarm=%b rgb=%h, want 1/f00", bus0.alarm, out0());
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus0.alarm !== 1'b0 || out0() !== 12'h000 || bus0.frame_count !== 2'd0) begin
      failures++;
      $display("FAIL mid_alarm_reset: alarm=%b rgb=%h count=%0d, want 0/000/0",
               bus0.alarm, out0(), bus0.frame_count);
    end
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus0.alarm !== 1'b0 || out0() !== 12'h5A3) begin
      failures++;
      $display("FAIL post_reset_residual: alarm=%b rgb=%h, want 0/5a3", bus0.alarm, out0());
    end
  endtask

  initial begin
    test_reset();
    test_frame_count();
    test_rising_edge();
    test_hold();
    test_border();
    test_blink();
    test_grey_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
